sm_hex_keypad_8: RTL and testbench
==================================

Name: sm_hex_keypad_8

Overview:
- 4x4 hex matrix keypad scanner; the input-side counterpart of the 8-digit hex display driver.
- Drives active-low rows and samples active-low columns, then debounces the key snapshot.
- Emits a one-cycle key event carrying a hex code.
- Shifts each accepted digit into a 32-bit number that can feed the display's number input directly.

Parameters:
- SCAN_DIV, 1000: clocks each row is driven before its columns are sampled (>= 4).
- DEBOUNCE, 4: consecutive identical full-matrix frames required before the debounced state updates (>= 1).

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- cols  input  4  keypad columns, active-low (external pull-ups); asynchronous to clock.
- rows  output  4  keypad rows, active-low one-hot.
- key_valid  output  1  one-clock pulse per accepted key press.
- key_code  output  4  code of the last accepted key, = row*4 + col.
- number  output  32  shift register of accepted digits; newest digit in [3:0].
- clear  input  1  synchronous clear of number.

Behaviour:
- Reset: one clock, asynchronous, active-low (clock/resetn). While resetn=0, all state clears:
  - Outputs: rows=4'b1110, key_valid=0, key_code=0, number=0.
  - Internal: divider=0, row index r=0, FSM=IDLE, raw/previous/debounced snapshots=0, stable count=0.
  - Synchronizer flops are set to 4'b1111.
- Reset asserted mid-press: any partial debounce or event is discarded. After release of reset, the key must be re-qualified from scratch.
- Column synchronizer: cols passes through a 2-flop synchronizer and is inverted to an active-high pressed vector.
- Divider: counts 0..SCAN_DIV-1. tick is asserted on the last count.
- Sampling: on tick, raw[r*4 +: 4] <= synced pressed vector. Columns therefore see SCAN_DIV-1 settle clocks (covering the synchronizer delay).
- Row advance: also on tick, r <= r+1 (mod 4) and rows <= ~(1 << next r). rows is registered and glitch-free.
- Frame end = tick with r=3. At frame end, the just-completed 16-bit raw (including the row-3 sample) is compared with prev, then prev <= raw:
  - Equal: count <= min(count+1, DEBOUNCE).
  - Different: count <= 1.
  - When count reaches DEBOUNCE: deb <= raw.
- FSM, evaluated on the clock after deb updates:
  - IDLE, deb has exactly one bit set: key_valid=1 for one clock, key_code=index, go to HELD.
  - IDLE, deb has two or more bits set: go to HELD with no event (ghost/chord rejection).
  - IDLE, deb=0: stay in IDLE.
  - HELD, deb=0: go to IDLE.
  - HELD otherwise: stay in HELD. Adding or removing keys while any key remains produces no event.
- Number shift: on key_valid, number <= {number[27:0], key_code}. Old digits fall off the top (wrap-around by truncation).
- clear:
  - number <= 0.
  - Same cycle as key_valid: clear wins and number=0; the key_valid/key_code pulse still occurs.
- Latency: from a stable press to key_valid is at most (DEBOUNCE+1)*4*SCAN_DIV + 4 clocks. Release is recognised after DEBOUNCE clean frames.
- key_code holds its value between events.

Decomposition:
- Shared package sm_keypad_pkg holds:
  - Constants KEY_ROWS=4, KEY_COLS=4.
  - The FSM state enum {IDLE, HELD}.
  - A function onehot16_index returning {valid_single, index[3:0]}.
- Natural sub-module sm_keypad_matrix_scan:
  - Contains the synchronizer, divider, row driver and raw-snapshot capture.
  - Outputs raw[15:0] and frame_done.
- The top level holds the debounce, FSM and number register.

Test Plan (SCAN_DIV=4, DEBOUNCE=2; frame = 16 clocks):
- Reset then idle, cols=4'hF -> rows=1110 during reset; afterwards the sequence 1110,1101,1011,0111 repeats, each row for 4 clocks; number=0; key_valid never asserts.
- Press key r2/c1 (cols=1101 whenever rows=1011), hold 10 frames -> exactly one key_valid within 3 frames + 4 clocks; key_code=4'h9; number=32'h00000009; no further pulses while held.
- Bounce: assert key r0/c1 for 1 frame only, then release -> no key_valid; number is unchanged.
- Press/release keys 1,2,3 (r0 c1,c2,c3), then 9 more keys -> number=32'h00000123 after the first three; after 12 keys, only the last 8 digits remain.
- Press r0/c0 and r3/c3 together, release r0/c0 only, then release all -> no key_valid throughout; a subsequent single press of r1/c2 gives key_code=4'h6.
- Pulse clear in the key_valid cycle of key 5 -> number=0 and key_valid/key_code=5 pulse; assert resetn=0 mid-press -> outputs return to their reset values, and the held key is re-accepted only after DEBOUNCE frames.

Source files
------------

// File: rtl/sm_keypad_pkg.sv
// ---------------------------------------------------------------------------
// sm_keypad_pkg
// Shared definitions for the 4x4 hex keypad scanner.
//   KEY_ROWS / KEY_COLS : matrix geometry
//   key_state_t         : key event FSM state (IDLE, HELD)
//   onehot16_index()    : returns {valid_single, index[3:0]} for a 16-bit
//                         key snapshot; valid_single is 1 only when exactly
//                         one key is pressed.
// ---------------------------------------------------------------------------
package sm_keypad_pkg;

    localparam int KEY_ROWS  = 4;
    localparam int KEY_COLS  = 4;
    localparam int KEY_COUNT = KEY_ROWS * KEY_COLS;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } key_state_t;

    function automatic logic [4:0] onehot16_index(input logic [15:0] vec);
        logic [3:0] idx;
        int         ones;
        idx  = 4'd0;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                ones = ones + 1;
                idx  = 4'(i);
            end
        end
        return {(ones == 1), idx};
    endfunction

endpackage

// File: rtl/sm_hex_keypad_8_if.sv
// ---------------------------------------------------------------------------
// sm_hex_keypad_8_if
// Key event / number bus between the keypad scanner and its consumer.
//   key_valid : one-clock pulse per accepted key press
//   key_code  : code of the last accepted key (row*4 + col)
//   number    : 32-bit shift register of accepted digits, newest in [3:0]
//   clear     : synchronous clear of number (driven by the consumer)
// master = scanner side, slave = consumer side.
// ---------------------------------------------------------------------------
interface sm_hex_keypad_8_if;

    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] number;
    logic        clear;

    modport master (
        output key_valid,
        output key_code,
        output number,
        input  clear
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  number,
        output clear
    );

endinterface

// File: rtl/sm_keypad_matrix_scan.sv
// ---------------------------------------------------------------------------
// sm_keypad_matrix_scan
// Drives the keypad rows one at a time (active-low) and captures the column
// state of each row into a 16-bit raw snapshot.
//   clock, resetn : system clock, async active-low reset
//   cols          : keypad columns, active-low, asynchronous to clock
//   rows          : keypad rows, active-low one-hot, registered
//   raw           : pressed-key snapshot, bit r*4+c = key at row r / col c
//   frame_done    : one-clock pulse once raw holds a complete frame
// ---------------------------------------------------------------------------
module sm_keypad_matrix_scan
    import sm_keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [KEY_COLS-1:0]  cols,
    output logic [KEY_ROWS-1:0]  rows,
    output logic [KEY_COUNT-1:0] raw,
    output logic                 frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [KEY_COLS-1:0] cols_meta;
    logic [KEY_COLS-1:0] cols_sync;
    logic [DIV_W-1:0]    div;
    logic [1:0]          r;
    logic [1:0]          r_next;
    logic                tick;

    assign tick   = (div == DIV_W'(SCAN_DIV - 1));
    assign r_next = r + 2'd1;

    // Synchronizer resets to "nothing pressed" (columns are pulled high).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cols_meta <= '1;
            cols_sync <= '1;
        end else begin
            cols_meta <= cols;
            cols_sync <= cols_meta;
        end
    end

    // A row is held for SCAN_DIV clocks and sampled on the last one, so the
    // columns get SCAN_DIV-1 clocks to settle through the synchronizer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div        <= '0;
            r          <= 2'd0;
            rows       <= 4'b1110;
            raw        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                div                  <= '0;
                r                    <= r_next;
                rows                 <= ~(4'b0001 << r_next);
                raw[{r, 2'b00} +: 4] <= ~cols_sync;
                // Registered so raw already contains the row-3 sample.
                frame_done           <= (r == 2'd3);
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/sm_hex_keypad_8.sv
// ---------------------------------------------------------------------------
// sm_hex_keypad_8
// 4x4 hex keypad scanner with frame debounce, single-key event generation
// and a 32-bit digit shift register that can feed an 8-digit hex display.
//   clock, resetn : system clock, async active-low reset
//   cols          : keypad columns, active-low, asynchronous
//   rows          : keypad rows, active-low one-hot
//   kp (master)   : key_valid / key_code / number out, clear in
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no key pressed; a single debounced key produces an event
// HELD  | one or more keys down; no events until all keys are released
// ---------------------------------------------------------------------------
module sm_hex_keypad_8
    import sm_keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [KEY_COLS-1:0] cols,
    output logic [KEY_ROWS-1:0] rows,
    sm_hex_keypad_8_if.master   kp
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic [KEY_COUNT-1:0] raw;
    logic                 frame_done;
    logic [KEY_COUNT-1:0] prev;
    logic [KEY_COUNT-1:0] deb;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    key_state_t           state;
    key_state_t           state_next;
    logic                 key_event;
    logic [4:0]           decode;
    logic                 key_valid_q;
    logic [3:0]           key_code_q;
    logic [31:0]          number_q;

    sm_keypad_matrix_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clock      (clock),
        .resetn     (resetn),
        .cols       (cols),
        .rows       (rows),
        .raw        (raw),
        .frame_done (frame_done)
    );

    // Debounce: count consecutive identical frames, saturating at DEBOUNCE.
    always_comb begin
        count_next = count;
        if (raw == prev) begin
            if (count < CNT_W'(DEBOUNCE)) begin
                count_next = count + CNT_W'(1);
            end
        end else begin
            count_next = CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev  <= '0;
            count <= '0;
            deb   <= '0;
        end else if (frame_done) begin
            prev  <= raw;
            count <= count_next;
            if (count_next == CNT_W'(DEBOUNCE)) begin
                deb <= raw;
            end
        end
    end

    assign decode = onehot16_index(deb);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Chords seen from IDLE go straight to HELD without an event.
    always_comb begin
        state_next = state;
        key_event  = 1'b0;
        case (state)
            IDLE: begin
                if (deb != '0) begin
                    state_next = HELD;
                    key_event  = decode[4];
                end
            end
            HELD: begin
                if (deb == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // clear has priority over the digit shift; the event pulse is unaffected.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            number_q    <= 32'h0;
        end else begin
            key_valid_q <= key_event;
            if (key_event) begin
                key_code_q <= decode[3:0];
            end
            if (kp.clear) begin
                number_q <= 32'h0;
            end else if (key_valid_q) begin
                number_q <= {number_q[27:0], key_code_q};
            end
        end
    end

    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.number    = number_q;

endmodule

// File: tb/tb_sm_hex_keypad_8.sv
// ---------------------------------------------------------------------------
// tb_sm_hex_keypad_8
// Directed bench for sm_hex_keypad_8 with SCAN_DIV=4, DEBOUNCE=2 (16-clock
// frames). A behavioural keypad matrix turns the pressed-key vector into
// column levels for whichever row the DUT is driving.
// ---------------------------------------------------------------------------
module tb_sm_hex_keypad_8;

    localparam int FRAME   = 16;
    localparam int LAT_MAX = 3 * 4 * 4 + 4;

    logic        clock;
    logic        resetn;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [15:0] keys;

    int checks;
    int errors;

    sm_hex_keypad_8_if kp_if ();

    sm_hex_keypad_8 #(
        .SCAN_DIV (4),
        .DEBOUNCE (2)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .cols   (cols),
        .rows   (rows),
        .kp     (kp_if.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        cols = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            if (!rows[rr]) begin
                for (int cc = 0; cc < 4; cc++) begin
                    if (keys[rr*4 + cc]) cols[cc] = 1'b0;
                end
            end
        end
    end

    // Advances n clocks, counting key_valid pulses and the first pulse's
    // position (1-based clock index) and code.
    task automatic run_clocks(input int n, output int pulses, output int first_at,
                              output logic [3:0] code);
        pulses   = 0;
        first_at = 0;
        code     = 4'h0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clock); #1;
            if (kp_if.key_valid === 1'b1) begin
                pulses++;
                if (first_at == 0) begin
                    first_at = i;
                    code     = kp_if.key_code;
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_rows;
        int         pulses;
        int         first_at;
        logic [3:0] code;
        resetn = 1'b0;
        keys   = 16'h0;
        kp_if.clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (rows !== 4'b1110) begin
            errors++; $display("FAIL reset_rows: got %b expected 1110", rows);
        end
        checks++;
        if (kp_if.key_valid !== 1'b0 || kp_if.key_code !== 4'h0 || kp_if.number !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b code=%h number=%h expected 0/0/0",
                     kp_if.key_valid, kp_if.key_code, kp_if.number);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            @(posedge clock); #1;
            exp_rows = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (rows !== exp_rows) begin
                errors++; $display("FAIL row_scan[%0d]: got %b expected %b", k, rows, exp_rows);
            end
        end
        run_clocks(4 * FRAME, pulses, first_at, code);
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL idle_no_event: got %0d pulses expected 0", pulses);
        end
        checks++;
        if (kp_if.number !== 32'h0) begin
            errors++; $display("FAIL idle_number: got %h expected 00000000", kp_if.number);
        end
    endtask

    task automatic test_single_press;
        int         pulses;
        int         first_at;
        logic [3:0] code;
        keys = 16'h0200;
        run_clocks(10 * FRAME, pulses, first_at, code);
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL press_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (first_at == 0 || first_at > LAT_MAX) begin
            errors++; $display("FAIL press_latency: got %0d clocks expected 1..%0d", first_at, LAT_MAX);
        end
        checks++;
        if (code !== 4'h9) begin
            errors++; $display("FAIL press_code: got %h expected 9", code);
        end
        checks++;
        if (kp_if.number !== 32'h0000_0009) begin
            errors++; $display("FAIL press_number: got %h expected 00000009", kp_if.number);
        end
        keys = 16'h0;
        run_clocks(4 * FRAME, pulses, first_at, code);
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL release_no_event: got %0d pulses expected 0", pulses);
        end
        checks++;
        if (kp_if.key_code !== 4'h9) begin
            errors++; $display("FAIL code_hold: got %h expected 9", kp_if.key_code);
        end
    endtask

    task automatic test_bounce;
        int         pulses;
        int         first_at;
        logic [3:0] code;
        keys = 16'h0002;
        run_clocks(FRAME, pulses, first_at, code);
        keys = 16'h0;
        run_clocks(6 * FRAME, pulses, first_at, code);
        checks++;
        if (pulses != 0 || first_at != 0) begin
            errors++; $display("FAIL bounce_no_event: got %0d pulses expected 0", pulses);
        end
        checks++;
        if (kp_if.number !== 32'h0000_0009) begin
            errors++; $display("FAIL bounce_number: got %h expected 00000009", kp_if.number);
        end
    endtask

    task automatic test_shift_sequence;
        logic [3:0]  seq [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                  4'h7, 4'h8, 4'hE, 4'hF, 4'h0, 4'hC};
        int          pulses;
        int          first_at;
        logic [3:0]  code;
        logic [15:0] onehot;
        kp_if.clear = 1'b1;
        @(posedge clock); #1;
        kp_if.clear = 1'b0;
        checks++;
        if (kp_if.number !== 32'h0) begin
            errors++; $display("FAIL clear_idle: got %h expected 00000000", kp_if.number);
        end
        for (int i = 0; i < 12; i++) begin
            onehot = 16'h0001 << seq[i];
            keys   = onehot;
            run_clocks(5 * FRAME, pulses, first_at, code);
            checks++;
            if (pulses != 1 || code !== seq[i]) begin
                errors++;
                $display("FAIL seq_key[%0d]: got %0d pulses code %h expected 1 pulse code %h",
                         i, pulses, code, seq[i]);
            end
            keys = 16'h0;
            run_clocks(4 * FRAME, pulses, first_at, code);
            if (i == 2) begin
                checks++;
                if (kp_if.number !== 32'h0000_0123) begin
                    errors++; $display("FAIL seq_number3: got %h expected 00000123", kp_if.number);
                end
            end
        end
        checks++;
        if (kp_if.number !== 32'h5678_EF0C) begin
            errors++; $display("FAIL seq_number12: got %h expected 5678ef0c", kp_if.number);
        end
    endtask

    task automatic test_chord;
        int         pulses;
        int         first_at;
        logic [3:0] code;
        keys = 16'h8001;
        run_clocks(5 * FRAME, pulses, first_at, code);
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL chord_press: got %0d pulses expected 0", pulses);
        end
        keys = 16'h8000;
        run_clocks(5 * FRAME, pulses, first_at, code);
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL chord_partial_release: got %0d pulses expected 0", pulses);
        end
        keys = 16'h0;
        run_clocks(4 * FRAME, pulses, first_at, code);
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL chord_release: got %0d pulses expected 0", pulses);
        end
        keys = 16'h0040;
        run_clocks(5 * FRAME, pulses, first_at, code);
        checks++;
        if (pulses != 1 || code !== 4'h6) begin
            errors++; $display("FAIL after_chord: got %0d pulses code %h expected 1 pulse code 6", pulses, code);
        end
        checks++;
        if (kp_if.number !== 32'h678E_F0C6) begin
            errors++; $display("FAIL after_chord_number: got %h expected 678ef0c6", kp_if.number);
        end
        keys = 16'h0;
        run_clocks(4 * FRAME, pulses, first_at, code);
    endtask

    task automatic test_clear_and_reset;
        int         pulses;
        int         first_at;
        logic [3:0] code;
        bit         seen;
        keys = 16'h0020;
        seen = 1'b0;
        for (int i = 0; i < LAT_MAX + 8 && !seen; i++) begin
            @(posedge clock); #1;
            if (kp_if.key_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL clear_event_timeout: got no key_valid expected one pulse");
        end else begin
            checks++;
            if (kp_if.key_code !== 4'h5) begin
                errors++; $display("FAIL clear_event_code: got %h expected 5", kp_if.key_code);
            end
            kp_if.clear = 1'b1;
            @(posedge clock); #1;
            kp_if.clear = 1'b0;
            checks++;
            if (kp_if.number !== 32'h0 || kp_if.key_valid !== 1'b0) begin
                errors++;
                $display("FAIL clear_priority: got number %h valid %b expected 00000000 0",
                         kp_if.number, kp_if.key_valid);
            end
        end
        keys = 16'h0;
        run_clocks(4 * FRAME, pulses, first_at, code);
        keys = 16'h0400;
        run_clocks(5 * FRAME, pulses, first_at, code);
        checks++;
        if (pulses != 1 || kp_if.number !== 32'h0000_000A || kp_if.key_code !== 4'hA) begin
            errors++;
            $display("FAIL pre_reset_key: got %0d pulses number %h code %h expected 1 0000000a a",
                     pulses, kp_if.number, kp_if.key_code);
        end
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (rows !== 4'b1110 || kp_if.key_valid !== 1'b0 || kp_if.key_code !== 4'h0 ||
            kp_if.number !== 32'h0) begin
            errors++;
            $display("FAIL midpress_reset: got rows %b valid %b code %h number %h expected 1110 0 0 00000000",
                     rows, kp_if.key_valid, kp_if.key_code, kp_if.number);
        end
        @(negedge clock);
        resetn = 1'b1;
        run_clocks(5 * FRAME, pulses, first_at, code);
        checks++;
        if (pulses != 1 || first_at <= 2 * FRAME || first_at > LAT_MAX) begin
            errors++;
            $display("FAIL requalify: got %0d pulses at clock %0d expected 1 pulse in %0d..%0d",
                     pulses, first_at, 2 * FRAME + 1, LAT_MAX);
        end
        checks++;
        if (code !== 4'hA || kp_if.number !== 32'h0000_000A) begin
            errors++; $display("FAIL requalify_value: got code %h number %h expected a 0000000a", code, kp_if.number);
        end
        keys = 16'h0;
        run_clocks(4 * FRAME, pulses, first_at, code);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        resetn      = 1'b0;
        keys        = 16'h0;
        kp_if.clear = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_shift_sequence();
        test_chord();
        test_clear_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
